data_ram_sram_like: RTL and testbench

Data-side memory responder for the core's sram-like data interface: the slave end of the data_req/data_addr_ok/data_data_ok protocol the core drives as initiator. It accepts byte, halfword and word loads and stores into an internal word-organised array, and returns in-order responses after a configurable latency. Up to DEPTH requests can be outstanding. Used in simulation benches and FPGA test tops alongside the instruction ROM.

---
 rtl/data_ram_sram_like.sv | 118 +++++++++++
 tb/tb_data_ram_sram_like.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_sram_like.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_sram_like
// Brief    : sram-like data memory slave with in-order, fixed-latency replies
// Revision : 1.0
// ============================================================================
module data_ram_sram_like #(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 1,
   parameter int DEPTH      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok
);

   localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                 c_CNT_W    = $clog2(DEPTH + 1);
   localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);
   localparam logic [3:0]         c_LAT_INIT = 4'(LATENCY - 1);

   logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_CNT_W-1:0]    r_count;
   logic                  w_valid [DEPTH];
   logic [3:0]            w_cnt   [DEPTH];
   logic [31:0]           w_data  [DEPTH];
   logic [ADDR_WIDTH-1:0] w_index;
   logic [31:0]           w_rword;
   logic [3:0]            w_be;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_unused_addr;

   assign w_index       = data_addr[ADDR_WIDTH+1:2];
   assign w_rword       = mem[w_index];
   assign w_unused_addr = ^data_addr;

   assign data_addr_ok = (r_count < c_DEPTH);
   assign w_push       = data_req & data_addr_ok;
   assign data_data_ok = w_valid[r_rd_ptr] & (w_cnt[r_rd_ptr] == 4'd0);
   assign w_pop        = data_data_ok;
   assign data_rdata   = data_data_ok ? w_data[r_rd_ptr] : 32'h0;

   // Misaligned stores leave every lane disabled but are still acknowledged.
   always_comb begin
      w_be = 4'b0000;
      case (data_size)
         2'd0:    w_be = 4'b0001 << data_addr[1:0];
         2'd1:    if (!data_addr[0]) w_be = data_addr[1] ? 4'b1100 : 4'b0011;
         default: if (data_addr[1:0] == 2'b00) w_be = 4'b1111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst && w_push && data_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) mem[w_index][8*b +: 8] <= data_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
         if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
         else if (!w_push && w_pop) r_count <= r_count - c_CNT_ONE;
      end
   end

   // Each slot counts down independently so a blocked head never stalls the
   // latency of the requests queued behind it.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      localparam logic [c_PTR_W-1:0] c_IDX = c_PTR_W'(i);

      logic        r_valid;
      logic [3:0]  r_cnt;
      logic [31:0] r_data;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_valid <= 1'b0;
            r_cnt   <= 4'd0;
            r_data  <= 32'h0;
         end else if (w_push && (r_wr_ptr == c_IDX)) begin
            r_valid <= 1'b1;
            r_cnt   <= c_LAT_INIT;
            r_data  <= data_wr ? 32'h0 : w_rword;
         end else begin
            if (w_pop && (r_rd_ptr == c_IDX)) r_valid <= 1'b0;
            if (r_valid && (r_cnt != 4'd0))   r_cnt   <= r_cnt - 4'd1;
         end
      end

      assign w_valid[i] = r_valid;
      assign w_cnt[i]   = r_cnt;
      assign w_data[i]  = r_data;
   end

endmodule
`default_nettype wire

// File: tb/tb_data_ram_sram_like.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_sram_like
// Brief    : three configurations of data_ram_sram_like against a queue model
// Revision : 1.0
// ============================================================================
module tb_data_ram_sram_like;

   localparam int c_AW = 6;
   localparam int c_NW = 2**c_AW;

   typedef struct {
      int          ready;
      logic [31:0] data;
   } rsp_t;

   logic clk = 1'b0;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_err  = 0;
   int   n_done = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic void fail_timeout(input string nm);
      n_chk++;
      n_err++;
      $display("FAIL %s: timed out (t=%0t)", nm, $time);
   endfunction

   // Byte lanes a store may touch; zero for misaligned halfword/word stores.
   function automatic logic [3:0] lanes(input logic [1:0] s, input logic [31:0] a);
      case (s)
         2'd0:    return 4'b0001 << a[1:0];
         2'd1:    return a[0] ? 4'b0000 : (4'b0011 << a[1:0]);
         default: return (a[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
      endcase
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_inst
      localparam int c_LAT = (k == 0) ? 1 : (k == 1) ? 3 : 5;
      localparam int c_DEP = (k == 2) ? 3 : 2;

      logic        rst, req, wr, addr_ok, data_ok;
      logic [1:0]  size;
      logic [31:0] addr, wdata, rdata;
      logic [31:0] mm [c_NW];
      rsp_t        q [$];

      data_ram_sram_like #(
         .ADDR_WIDTH (c_AW),
         .LATENCY    (c_LAT),
         .DEPTH      (c_DEP)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .data_req     (req),
         .data_wr      (wr),
         .data_size    (size),
         .data_addr    (addr),
         .data_wdata   (wdata),
         .data_rdata   (rdata),
         .data_addr_ok (addr_ok),
         .data_data_ok (data_ok)
      );

      // Model: queue of replies, each due LATENCY cycles after acceptance,
      // released in order at most one per cycle.
      always @(negedge clk) begin
         logic        eaok, eok;
         logic [31:0] erd;
         logic [3:0]  be;
         int          idx;
         rsp_t        e;
         if (!rst) begin
            q.delete();
            eaok = 1'b1;
            eok  = 1'b0;
            erd  = 32'h0;
         end else begin
            eaok = (q.size() < c_DEP);
            eok  = (q.size() > 0) && (q[0].ready <= cyc);
            erd  = eok ? q[0].data : 32'h0;
         end
         chk($sformatf("i%0d addr_ok", k), {31'h0, addr_ok}, {31'h0, eaok});
         chk($sformatf("i%0d data_ok", k), {31'h0, data_ok}, {31'h0, eok});
         chk($sformatf("i%0d rdata", k), rdata, erd);
         if (rst) begin
            if (eok) void'(q.pop_front());
            if (req && eaok) begin
               idx = int'(addr[c_AW+1:2]);
               if (wr) begin
                  be = lanes(size, addr);
                  for (int b = 0; b < 4; b++)
                     if (be[b]) mm[idx][8*b +: 8] = wdata[8*b +: 8];
                  e.data = 32'h0;
               end else begin
                  e.data = mm[idx];
               end
               e.ready = cyc + c_LAT;
               q.push_back(e);
            end
         end
      end

      // Called just after a rising edge; returns just after the accepting edge.
      task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
         req = 1'b1; wr = w; size = s; addr = a; wdata = d;
         for (int t = 0; ; t++) begin
            @(negedge clk);
            if (addr_ok) break;
            if (t >= 60) begin
               fail_timeout($sformatf("i%0d addr_ok wait", k));
               break;
            end
         end
         @(posedge clk);
         #1 req = 1'b0;
      endtask

      task automatic collect(input int n, output logic [31:0] last, output int got);
         got  = 0;
         last = 32'h0;
         for (int t = 0; (t < 60 * n) && (got < n); t++) begin
            @(negedge clk);
            if (data_ok) begin
               got++;
               last = rdata;
            end
         end
         if (got < n) fail_timeout($sformatf("i%0d data_ok wait", k));
         @(posedge clk);
         #1;
      endtask

      initial begin : stim
         logic [31:0] last;
         int          got;
         rst = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0;
         for (int i = 0; i < c_NW; i++) begin
            mm[i] = (i == 4) ? 32'h11223344 : $urandom;
            u_dut.mem[i] <= mm[i];
         end
         @(negedge clk);
         chk($sformatf("i%0d reset addr_ok", k), {31'h0, addr_ok}, 32'h1);
         chk($sformatf("i%0d reset data_ok", k), {31'h0, data_ok}, 32'h0);
         chk($sformatf("i%0d reset rdata", k), rdata, 32'h0);
         repeat (2) @(posedge clk);
         #1 rst = 1'b1;

         fork
            issue(1'b0, 2'd2, 32'h10, 32'h0);
            collect(1, last, got);
         join
         chk($sformatf("i%0d first load", k), last, 32'h11223344);
         @(negedge clk);
         chk($sformatf("i%0d idle data_ok", k), {31'h0, data_ok}, 32'h0);
         chk($sformatf("i%0d idle rdata", k), rdata, 32'h0);
         @(posedge clk);
         #1;

         fork
            begin
               issue(1'b1, 2'd0, 32'h11, 32'h0000AA00);
               issue(1'b1, 2'd1, 32'h12, 32'hBEEF0000);
               issue(1'b0, 2'd2, 32'h10, 32'h0);
            end
            collect(3, last, got);
         join
         chk($sformatf("i%0d byte/half count", k), got, 3);
         chk($sformatf("i%0d byte/half merge", k), last, 32'hBEEFAA44);

         fork
            begin
               issue(1'b1, 2'd2, 32'h13, 32'hFFFFFFFF);
               issue(1'b0, 2'd2, 32'h10, 32'h0);
            end
            collect(2, last, got);
         join
         chk($sformatf("i%0d misaligned count", k), got, 2);
         chk($sformatf("i%0d misaligned load", k), last, 32'hBEEFAA44);
         chk($sformatf("i%0d misaligned mem", k), u_dut.mem[4], 32'hBEEFAA44);

         fork
            for (int i = 0; i < 8; i++) issue(1'b0, 2'd2, 32'(i * 4), 32'h0);
            collect(8, last, got);
         join
         chk($sformatf("i%0d burst count", k), got, 8);
         chk($sformatf("i%0d burst last", k), last, mm[7]);

         issue(1'b0, 2'd2, 32'h0, 32'h0);
         issue(1'b0, 2'd2, 32'h4, 32'h0);
         rst = 1'b0;
         #1;
         chk($sformatf("i%0d async addr_ok", k), {31'h0, addr_ok}, 32'h1);
         chk($sformatf("i%0d async data_ok", k), {31'h0, data_ok}, 32'h0);
         repeat (2) @(posedge clk);
         #1 rst = 1'b1;
         repeat (8) @(posedge clk);
         #1;
         fork
            issue(1'b0, 2'd2, 32'h10, 32'h0);
            collect(1, last, got);
         join
         chk($sformatf("i%0d load after reset", k), last, 32'hBEEFAA44);

         for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end else begin
               issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     $urandom & 32'hFFFF_FF1F, $urandom);
            end
         end
         repeat (c_LAT * c_DEP + 10) @(posedge clk);
         @(negedge clk);
         chk($sformatf("i%0d drained addr_ok", k), {31'h0, addr_ok}, 32'h1);
         chk($sformatf("i%0d drained data_ok", k), {31'h0, data_ok}, 32'h0);
         n_done++;
      end
   end

   initial begin
      for (int t = 0; (t < 20000) && (n_done < 3); t++) @(posedge clk);
      if (n_done < 3) fail_timeout("instances finishing");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
